// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a time,
// and buffers returned {PC, instr} pairs for decode. Redirects flush the buffer.
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] fifo_pc_q  [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_ins_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            handshake, push, pop;
    logic            unused_target_lsbs;

    assign unused_target_lsbs = ^PCTarget[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A request is only issued when a buffer slot is free, so a push never overflows.
    assign imem_req  = (state_q == IDLE) && (count_q < CW'(FIFO_DEPTH)) && !PCSrc && !reset;
    assign imem_addr = fetch_pc_q;
    assign handshake = imem_req && imem_ready;
    assign push      = (state_q == WAIT) && imem_rvalid && !PCSrc;
    assign pop       = if_valid && id_ready && !PCSrc;

    assign if_valid  = (count_q != '0) && !reset;
    assign instr     = if_valid ? fifo_ins_q[rd_ptr_q] : '0;
    assign PC        = if_valid ? fifo_pc_q[rd_ptr_q]  : '0;
    assign PCPlus4   = if_valid ? fifo_pc_q[rd_ptr_q] + XLEN'(4) : '0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: if (handshake) begin
                state_d    = WAIT;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            // A response coinciding with a redirect is simply dropped.
            WAIT:    if (imem_rvalid) state_d = IDLE;
                     else if (PCSrc)  state_d = DISCARD;
            DISCARD: if (imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (PCSrc) fetch_pc_d = {PCTarget[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_VECTOR;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (handshake) req_pc_q <= fetch_pc_q;
            if (PCSrc) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (!push && pop) count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]  <= req_pc_q;
            fifo_ins_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage; successor to the fixed PC-mux/PC-flop/PC+4 front end of the single-cycle core.
- Owns the fetch PC and issues word requests to instruction memory over a ready/valid handshake, with one request outstanding at a time.
- Buffers returned {PC, instr} pairs in a small FIFO feeding decode, which consumes them through a valid/ready handshake.
- Handles branch/jump redirect (PCSrc/PCTarget): flushes the buffer and discards any in-flight response.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_VECTOR, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, entries in the fetch buffer; power of two, at least 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- PCSrc  in  1  redirect request from execute.
- PCTarget  in  XLEN  redirect target; bits [1:0] ignored.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  word address; bits [1:0] always 0.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  XLEN  response instruction.
- if_valid  out  1  buffer head valid.
- id_ready  in  1  decode accepts the head.
- instr  out  XLEN  head instruction.
- PC  out  XLEN  head PC.
- PCPlus4  out  XLEN  PC + 4, modulo 2^XLEN.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - On a reset edge: fetch_pc = RESET_VECTOR, FIFO count = 0, state = IDLE. Reset mid-transaction drops everything, including a pending response.
  - While reset is high: imem_req = 0 and if_valid = 0. instr, PC and PCPlus4 read 0 while if_valid = 0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request accepted, response will be kept.
  - DISCARD: request accepted, response will be dropped.
- Request issue:
  - imem_req = (state==IDLE) && (count < FIFO_DEPTH) && !PCSrc && !reset.
  - imem_addr = fetch_pc.
  - imem_req is combinational from registered state, so the first request appears in the first cycle after reset deasserts.
  - Handshake occurs when imem_req && imem_ready. On it: req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN), state -> WAIT.
  - imem_req with imem_ready = 0: hold imem_req and imem_addr stable.
- Response handling:
  - In WAIT, imem_rvalid pushes {req_pc, imem_rdata} into the FIFO, then state -> IDLE.
  - In DISCARD, imem_rvalid pushes nothing, then state -> IDLE.
  - imem_rvalid in IDLE is ignored.
  - Request latency is 1 cycle minimum; response latency is arbitrary. Peak throughput is one instruction per 2 cycles.
- Space reservation:
  - A request is issued only when count < FIFO_DEPTH.
  - With one outstanding request and no new issue until IDLE, every push has a free slot. A push never overflows, even with a simultaneous pop.
- Output:
  - if_valid = (count != 0).
  - instr, PC and PCPlus4 come from the FIFO head.
  - Pop occurs when if_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Redirect (PCSrc = 1):
  - Next edge: fetch_pc <= {PCTarget[XLEN-1:2], 2'b00} and count <= 0, so if_valid = 0 the following cycle.
  - A pop in the redirect cycle is allowed, since decode sees its data combinationally, but it has no effect on the flushed state.
  - State WAIT -> DISCARD.
  - WAIT with imem_rvalid in the same cycle: the response is dropped, state -> IDLE.
  - No request is issued in the redirect cycle, because imem_req is forced low. The target is requested from the next cycle on.
  - PCSrc in DISCARD keeps state DISCARD and updates fetch_pc again (last redirect wins).
- Precedence: reset > PCSrc > response/push/pop > request issue.

Test Plan:
- Reset, then imem_ready = 1 and rvalid 1 cycle after each grant, id_ready = 1 → addresses 0x0, 0x4, 0x8, 0xC issued every 2 cycles. PC/instr pairs emerge in order with PCPlus4 = PC + 4. Reset held mid-run → imem_req and if_valid go low next cycle, and fetch restarts at RESET_VECTOR.
- id_ready = 0 with FIFO_DEPTH = 2 → exactly two requests (0x0, 0x4), then imem_req stays 0. Raise id_ready → head 0x0 popped, a request for 0x8 issues the next cycle, and no data is lost.
- Request outstanding (WAIT), PCSrc = 1 with PCTarget = 0x103 → the late response is dropped and the next imem_addr = 0x100. The first if_valid carries PC = 0x100.
- PCSrc asserted in the same cycle as imem_rvalid → that instruction never appears and the buffer is empty next cycle. Two redirects (0x200 then 0x300) during DISCARD → the next request is 0x300.
- imem_ready held low 5 cycles → imem_req and imem_addr stay stable, and no fetch_pc advance occurs. With XLEN = 32, RESET_VECTOR = 32'hFFFF_FFFC → the second request wraps to 0x0.
